// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - pipeline, memory and fill bus bundle for the cache refill sequencer
interface cache_refill_ctrl_if #(
    parameter int LINES       = 32,
    parameter int BLOCK_BYTES = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = DATA_W * BLOCK_BYTES;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic              hit;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_we;
    logic [LINES-1:0]  line_sel;
    logic [BLK_W-1:0]  fill_block;
    logic [TAG_W-1:0]  fill_tag;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, hit,
        input  mem_ack, mem_rvalid, mem_rdata,
        output stall, mem_req, mem_addr,
        output fill_we, line_sel, fill_block, fill_tag
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, hit,
        output mem_ack, mem_rvalid, mem_rdata,
        input  stall, mem_req, mem_addr,
        input  fill_we, line_sel, fill_block, fill_tag
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss sequencer: stall, fetch block bytewise, write line one-hot
// Optional miss/stall counters are built when REFILL_STATS_EN is defined.
module cache_refill_ctrl #(
    parameter int LINES       = 32,
    parameter int BLOCK_BYTES = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8
) (
    input  logic clk,
    input  logic reset,
    cache_refill_ctrl_if.master bus
`ifdef REFILL_STATS_EN
    ,
    output logic [15:0] miss_count,
    output logic [31:0] stall_cycles
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = DATA_W * BLOCK_BYTES;

    typedef enum logic [2:0] {IDLE, REQ, FILL, UPDATE, RESUME} state_t;

    state_t            state;
    logic [ADDR_W-1:0] capAddr;
    logic              capWrite;
    logic [DATA_W-1:0] capWdata;
    logic [OFF_W-1:0]  beatCnt;
    logic [BLK_W-1:0]  blockReg;
    logic [BLK_W-1:0]  nextBlock;
    logic              missNow;
    logic              lastBeat;

    assign missNow    = bus.req_valid & ~bus.hit & (state == IDLE);
    assign bus.stall  = (state != IDLE) | missNow;
    assign lastBeat   = (beatCnt == OFF_W'(BLOCK_BYTES - 1));
    assign bus.fill_block = blockReg;

    // The store byte overrides whatever memory returned for its offset on the final beat.
    always_comb begin
        nextBlock = blockReg;
        nextBlock[int'(beatCnt)*DATA_W +: DATA_W] = bus.mem_rdata;
        if (capWrite && lastBeat)
            nextBlock[int'(capAddr[OFF_W-1:0])*DATA_W +: DATA_W] = capWdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            capAddr      <= '0;
            capWrite     <= 1'b0;
            capWdata     <= '0;
            beatCnt      <= '0;
            blockReg     <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.fill_we  <= 1'b0;
            bus.line_sel <= '0;
            bus.fill_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (missNow) begin
                        capAddr      <= bus.req_addr;
                        capWrite     <= bus.req_write;
                        capWdata     <= bus.req_wdata;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        beatCnt     <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_rvalid) begin
                        blockReg <= nextBlock;
                        beatCnt  <= beatCnt + 1'b1;
                        if (lastBeat) begin
                            bus.fill_we  <= 1'b1;
                            bus.line_sel <= LINES'(1) << capAddr[OFF_W +: IDX_W];
                            bus.fill_tag <= capAddr[ADDR_W-1 -: TAG_W];
                            state        <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    bus.fill_we  <= 1'b0;
                    bus.line_sel <= '0;
                    state        <= RESUME;
                end
                RESUME:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REFILL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (missNow && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (bus.stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - vector table, corner sequences and randomized refills against a transaction model
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_refill_ctrl_if bus();
`ifdef REFILL_STATS_EN
    logic [15:0] missCount;
    logic [31:0] stallCycles;
`endif

    cache_refill_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef REFILL_STATS_EN
        ,
        .miss_count(missCount),
        .stall_cycles(stallCycles)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        int          ackDelay;
        logic        gap;
        int          pat;
        logic [31:0] expMemAddr;
        logic [31:0] expLineSel;
        logic [21:0] expTag;
        int          expStall;
    } missVec_t;

    typedef struct {
        logic        rv;
        logic        hit;
        logic [31:0] addr;
        logic        expStall;
    } hitVec_t;

    int tests = 0;
    int fails = 0;
    logic [7:0] memBytes [32];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid = 1'b0; bus.hit = 1'b1; bus.req_addr = '0;
        bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    function automatic logic [255:0] modelBlock(input missVec_t v);
        logic [255:0] b;
        for (int k = 0; k < 32; k++)
            b[8*k +: 8] = (v.wr && k == int'(v.addr % 32)) ? v.wdata : memBytes[k];
        return b;
    endfunction

    function automatic missVec_t randVec();
        missVec_t v;
        v.addr       = $urandom;
        v.wr         = 1'($urandom_range(0, 1));
        v.wdata      = 8'($urandom);
        v.ackDelay   = int'($urandom_range(0, 4));
        v.gap        = 1'($urandom_range(0, 1));
        v.pat        = 2;
        v.expMemAddr = v.addr - (v.addr % 32);
        v.expLineSel = 32'd1 << ((v.addr / 32) % 32);
        v.expTag     = 22'(v.addr / 1024);
        v.expStall   = 4 + v.ackDelay + (v.gap ? 64 : 32);
        return v;
    endfunction

    task automatic runMiss(input missVec_t v);
        logic [255:0] expBlock, gotBlock;
        logic [31:0]  firstAddr, gotLine;
        logic [21:0]  gotTag;
        int stallCnt = 0, reqCyc = 0, weCnt = 0, beats = 0, fillCyc = 0, cyc = 0;
        bit acked = 0, addrMoved = 0;
        gotBlock = '0; firstAddr = '0; gotLine = '0; gotTag = '0;
        for (int k = 0; k < 32; k++)
            memBytes[k] = (v.pat == 0) ? 8'(k) : (v.pat == 1) ? 8'h11 : 8'($urandom);
        expBlock = modelBlock(v);

        bus.req_valid = 1'b1; bus.hit = 1'b0; bus.req_addr = v.addr;
        bus.req_write = v.wr; bus.req_wdata = v.wdata;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        if (bus.stall) stallCnt++;
        tick();
        while (cyc < 400) begin
            cyc++;
            bus.req_valid = (weCnt == 0) ? 1'($urandom) : 1'b0;
            bus.req_addr  = $urandom; bus.req_write = 1'($urandom);
            bus.req_wdata = 8'($urandom); bus.hit = 1'($urandom);
            bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'($urandom);
            if (bus.mem_req) begin
                reqCyc++;
                if (reqCyc == 1) firstAddr = bus.mem_addr;
                else if (bus.mem_addr !== firstAddr) addrMoved = 1;
                bus.mem_rvalid = 1'($urandom);
                if (reqCyc == v.ackDelay + 1) begin
                    bus.mem_ack = 1'b1;
                    acked = 1;
                end
            end else if (acked && beats < 32) begin
                fillCyc++;
                if (!v.gap || fillCyc % 2 == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = memBytes[beats];
                    beats++;
                end
            end
            if (bus.fill_we) begin
                weCnt++;
                gotBlock = bus.fill_block; gotLine = bus.line_sel; gotTag = bus.fill_tag;
            end
            #1;
            if (!bus.stall) break;
            stallCnt++;
            tick();
        end
        check("mem_addr", firstAddr, v.expMemAddr);
        check("mem_addr_stable", addrMoved, 0);
        check("mem_req_cycles", reqCyc, v.ackDelay + 1);
        check("fill_we_pulses", weCnt, 1);
        check("line_sel", gotLine, v.expLineSel);
        check("fill_tag", gotTag, v.expTag);
        check("fill_block", gotBlock, expBlock);
        check("stall_cycles", stallCnt, v.expStall);
        check("idle_outputs", {bus.mem_req, bus.fill_we, bus.line_sel}, 0);
        check("fill_block_hold", bus.fill_block, expBlock);
        idleInputs();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        missVec_t vecs [4];
        hitVec_t  hits [4];
        int weSeen, stallSeen;

        vecs[0] = '{32'h1234_5ABC, 1'b0, 8'h00, 0, 1'b0, 0, 32'h1234_5AA0, 32'h0020_0000, 22'h048D16, 36};
        vecs[1] = '{32'h0000_0403, 1'b1, 8'hA5, 0, 1'b0, 1, 32'h0000_0400, 32'h0000_0001, 22'h000001, 36};
        vecs[2] = '{32'hDEAD_BEEF, 1'b0, 8'h00, 5, 1'b1, 2, 32'hDEAD_BEE0, 32'h0080_0000, 22'h37AB6F, 73};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 8'h5A, 1, 1'b0, 2, 32'hFFFF_FFE0, 32'h8000_0000, 22'h3FFFFF, 37};
        hits[0] = '{1'b1, 1'b1, 32'h0000_0040, 1'b0};
        hits[1] = '{1'b0, 1'b0, 32'h0000_0040, 1'b0};
        hits[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
        hits[3] = '{1'b1, 1'b0, 32'h0000_0040, 1'b1};

        idleInputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_fill_we", bus.fill_we, 0);
        check("rst_line_sel", bus.line_sel, 0);
        check("rst_fill_block", bus.fill_block, 0);
        check("rst_fill_tag", bus.fill_tag, 0);
        tick();
        reset = 1'b1;
        tick();

        // Miss rows only check the combinational stall; req_valid drops before the edge.
        foreach (hits[i]) begin
            bus.req_valid = hits[i].rv; bus.hit = hits[i].hit; bus.req_addr = hits[i].addr;
            #1;
            check("hit_stall", bus.stall, hits[i].expStall);
            if (hits[i].expStall) bus.req_valid = 1'b0;
            tick();
            check("hit_no_mem_req", {bus.mem_req, bus.stall}, 0);
        end
        idleInputs();
        tick();

        foreach (vecs[i]) runMiss(vecs[i]);

        // Reset after 10 fill beats
        bus.req_valid = 1'b1; bus.hit = 1'b0; bus.req_addr = 32'h0000_1234;
        tick();
        bus.req_valid = 1'b0; bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'(8'hC0 + i);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_stall", bus.stall, 0);
        check("midrst_mem_req", bus.mem_req, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        check("midrst_fill_we", bus.fill_we, 0);
        check("midrst_line_sel", bus.line_sel, 0);
        check("midrst_fill_block", bus.fill_block, 0);
        check("midrst_fill_tag", bus.fill_tag, 0);
        weSeen = 0; stallSeen = 0;
        for (int i = 0; i < 40; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'($urandom);
            if (i == 2) reset = 1'b1;
            #1;
            if (bus.fill_we) weSeen++;
            if (bus.stall) stallSeen++;
            tick();
        end
        check("midrst_no_fill_we", weSeen, 0);
        check("midrst_no_stall", stallSeen, 0);
        idleInputs();
        tick();
        runMiss(vecs[0]);

        for (int i = 0; i < 16; i++) runMiss(randVec());

`ifdef REFILL_STATS_EN
        reset = 1'b0;
        #1;
        check("stats_rst_miss", missCount, 0);
        check("stats_rst_stall", stallCycles, 0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) runMiss(vecs[0]);
        check("stats_miss_count", missCount, 3);
        check("stats_stall_cycles", stallCycles, 108);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
